// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD-line frame path: FSM states, CRC7 constants
// and a one-bit CRC7 update used by both the transmit and receive sides.
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CRC   = 2'd2,
    ST_END   = 2'd3
  } tx_state_e;

  localparam logic [6:0] CRC7_POLY       = 7'h09;
  localparam int         CRC7_LEN        = 7;
  localparam int         CMD_PAYLOAD_LEN = 40;
  localparam int         R2_PAYLOAD_LEN  = 135;

  // x^7 + x^3 + 1, feedback taken from the MSB.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_frame_serializer_crc7.sv
// Serial CRC7 accumulator, one bit per shift_en cycle; shared with the
// response receive path.
module crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic       sd_clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  // Clear wins over shift so a new frame always starts from zero.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (shift_en) begin
      crc_d = crc7_step(crc_q, din);
    end
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_frame_serializer.sv
// CMD-line frame transmitter: variable-length MSB-first payload, optional CRC7,
// end bit, with pad output enable and load/complete/length-error handshakes.
module sd_cmd_frame_serializer
  import sd_cmd_pkg::*;
#(
  parameter int PAYLOAD_MAX = 136,
  parameter int LEN_W       = 8
) (
  input  logic                   sd_clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   load_send,
  input  logic [LEN_W-1:0]       frame_len,
  input  logic                   crc_en,
  input  logic [PAYLOAD_MAX-1:0] parallel,
  output logic                   serial,
  output logic                   cmd_oe,
  output logic                   busy,
  output logic                   ack,
  output logic                   complete,
  output logic                   len_err
);

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(PAYLOAD_MAX);
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CRC_LAST = LEN_W'(CRC7_LEN - 1);

  tx_state_e              state_q, state_d;
  logic [PAYLOAD_MAX-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   crc_en_q, crc_en_d;
  logic                   serial_q, serial_d;
  logic                   cmd_oe_q, cmd_oe_d;
  logic                   ack_q, ack_d;
  logic                   complete_q, complete_d;
  logic                   len_err_q, len_err_d;

  logic                   crc_clear;
  logic                   crc_shift;
  logic [6:0]             crc_value;
  logic                   len_ok;

  assign len_ok = (frame_len != '0) && (frame_len <= MAX_LEN);

  crc7_serial u_crc7 (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (crc_clear),
    .shift_en (crc_shift),
    .din      (shreg_q[PAYLOAD_MAX-1]),
    .crc      (crc_value)
  );

  // The line is registered one cycle behind the state, so END spends one
  // enabled cycle launching the end bit and a second one retiring the frame.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    crc_en_d   = crc_en_q;
    serial_d   = serial_q;
    cmd_oe_d   = cmd_oe_q;
    ack_d      = 1'b0;
    complete_d = 1'b0;
    len_err_d  = 1'b0;
    crc_clear  = 1'b0;
    crc_shift  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_send) begin
          if (len_ok) begin
            shreg_d   = parallel;
            bit_cnt_d = frame_len - CNT_ONE;
            crc_en_d  = crc_en;
            crc_clear = 1'b1;
            ack_d     = 1'b1;
            state_d   = ST_SHIFT;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (enable) begin
          serial_d  = shreg_q[PAYLOAD_MAX-1];
          cmd_oe_d  = 1'b1;
          shreg_d   = {shreg_q[PAYLOAD_MAX-2:0], 1'b0};
          crc_shift = 1'b1;
          if (bit_cnt_q == '0) begin
            if (crc_en_q) begin
              state_d   = ST_CRC;
              bit_cnt_d = CRC_LAST;
            end else begin
              state_d   = ST_END;
              bit_cnt_d = CNT_ONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - CNT_ONE;
          end
        end
      end

      ST_CRC: begin
        if (enable) begin
          serial_d = crc_value[bit_cnt_q[2:0]];
          if (bit_cnt_q == '0) begin
            state_d   = ST_END;
            bit_cnt_d = CNT_ONE;
          end else begin
            bit_cnt_d = bit_cnt_q - CNT_ONE;
          end
        end
      end

      ST_END: begin
        if (enable) begin
          serial_d = 1'b1;
          if (bit_cnt_q != '0) begin
            bit_cnt_d = '0;
          end else begin
            cmd_oe_d   = 1'b0;
            complete_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      crc_en_q   <= 1'b0;
      serial_q   <= 1'b1;
      cmd_oe_q   <= 1'b0;
      ack_q      <= 1'b0;
      complete_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      crc_en_q   <= crc_en_d;
      serial_q   <= serial_d;
      cmd_oe_q   <= cmd_oe_d;
      ack_q      <= ack_d;
      complete_q <= complete_d;
      len_err_q  <= len_err_d;
    end
  end

  assign serial   = serial_q;
  assign cmd_oe   = cmd_oe_q;
  assign busy     = (state_q != ST_IDLE);
  assign ack      = ack_q;
  assign complete = complete_q;
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_sd_cmd_frame_serializer.sv
// Scoreboard bench for sd_cmd_frame_serializer: stimulus pushes expected line
// bits and frame summaries, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_sd_cmd_frame_serializer;
  import sd_cmd_pkg::*;

  localparam int PMAX = 136;
  localparam int LW   = 8;

  typedef struct {
    int nbits;
    int oeCycles;
  } done_t;

  logic            sd_clock  = 1'b0;
  logic            reset     = 1'b0;
  logic            enable    = 1'b1;
  logic            load_send = 1'b0;
  logic [LW-1:0]   frame_len = '0;
  logic            crc_en    = 1'b0;
  logic [PMAX-1:0] parallel  = '0;
  logic            serial, cmd_oe, busy, ack, complete, len_err;

  int    errors = 0;
  int    checks = 0;
  bit    bitQ[$];
  done_t doneQ[$];
  int    ackSeen = 0, ackExp = 0, lenErrSeen = 0;
  int    bitsInFrame = 0, oeInFrame = 0;
  logic  enAtEdge = 1'b0, lastSerial = 1'b1, ackPending = 1'b0;

  always #5 sd_clock = ~sd_clock;

  sd_cmd_frame_serializer #(.PAYLOAD_MAX(PMAX), .LEN_W(LW)) dut (
    .sd_clock  (sd_clock),
    .reset     (reset),
    .enable    (enable),
    .load_send (load_send),
    .frame_len (frame_len),
    .crc_en    (crc_en),
    .parallel  (parallel),
    .serial    (serial),
    .cmd_oe    (cmd_oe),
    .busy      (busy),
    .ack       (ack),
    .complete  (complete),
    .len_err   (len_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Reference CRC7: remainder of M(x)*x^7 divided by x^7+x^3+1, by long division.
  function automatic logic [6:0] crc7Ref(input bit msg[$]);
    bit         a[$];
    logic [7:0] g;
    logic [6:0] r;
    g = {1'b1, CRC7_POLY};
    a = msg;
    repeat (7) a.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (a[i])
        for (int j = 0; j < 8; j++) a[i+j] = a[i+j] ^ g[7-j];
    for (int j = 0; j < 7; j++) r[6-j] = a[msg.size()+j];
    return r;
  endfunction

  function automatic logic [PMAX-1:0] randPayload();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[159:24];
  endfunction

  task automatic pushModel(input int len, input bit ce, input logic [PMAX-1:0] p, input int oeExp);
    bit         msg[$];
    logic [6:0] c;
    for (int i = 0; i < len; i++) msg.push_back(p[PMAX-1-i]);
    foreach (msg[i]) bitQ.push_back(msg[i]);
    if (ce) begin
      c = crc7Ref(msg);
      for (int j = 6; j >= 0; j--) bitQ.push_back(c[j]);
    end
    bitQ.push_back(1'b1);
    doneQ.push_back(done_t'{nbits: len + 7*int'(ce) + 1, oeCycles: oeExp});
  endtask

  task automatic pushLiteral(input logic [47:0] lit, input int oeExp);
    for (int i = 47; i >= 0; i--) bitQ.push_back(lit[i]);
    doneQ.push_back(done_t'{nbits: 48, oeCycles: oeExp});
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic applyStimulus(input int len, input bit ce, input logic [PMAX-1:0] p);
    frame_len = LW'(len);
    crc_en    = ce;
    parallel  = p;
    load_send = 1'b1;
    @(posedge sd_clock); #1;
    ackExp++;
    checkOutput("ack_on_load", ack, 1);
    load_send = 1'b0;
    parallel  = randPayload();
    crc_en    = $urandom_range(0, 1);
  endtask

  task automatic waitIdle(input bit randEn);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge sd_clock); #1;
      if (randEn) enable = $urandom_range(0, 1);
      n++;
    end
    if (busy) failNow("wait_idle", "busy still 1 after 3000 cycles, expected 0");
    enable = 1'b1;
  endtask

  task automatic applyBadLength(input int len);
    frame_len = LW'(len);
    crc_en    = 1'b1;
    load_send = 1'b1;
    @(posedge sd_clock); #1;
    load_send = 1'b0;
    checkOutput($sformatf("len_err_%0d", len), len_err, 1);
    checkOutput($sformatf("no_ack_%0d", len), ack, 0);
    checkOutput($sformatf("line_idle_%0d", len), {busy, cmd_oe, serial}, 3'b001);
    @(posedge sd_clock); #1;
    checkOutput($sformatf("len_err_pulse_%0d", len), len_err, 0);
  endtask

  always @(posedge sd_clock) enAtEdge <= enable;

  // Monitor: one line bit per enabled edge while cmd_oe is high.
  always @(negedge sd_clock) begin
    done_t d;
    bit    e;
    if (!reset) begin
      bitsInFrame = 0;
      oeInFrame   = 0;
      ackPending  = 1'b0;
      lastSerial  = 1'b1;
    end else begin
      if (cmd_oe) oeInFrame++;
      if (ackPending && enAtEdge) begin
        checkOutput("first_bit_latency", cmd_oe, 1);
        ackPending = 1'b0;
      end
      if (cmd_oe && enAtEdge) begin
        if (bitQ.size() == 0) begin
          failNow("unexpected_bit", $sformatf("line bit %0b with no expected bit queued", serial));
        end else begin
          e = bitQ.pop_front();
          checkOutput($sformatf("bit%0d", bitsInFrame), serial, e);
        end
        bitsInFrame++;
      end else if (cmd_oe) begin
        checkOutput("stall_hold", serial, lastSerial);
      end
      if (complete) begin
        if (doneQ.size() == 0) begin
          failNow("unexpected_complete", "complete=1, expected no frame completion");
        end else begin
          d = doneQ.pop_front();
          checkOutput("frame_bits", bitsInFrame, d.nbits);
          if (d.oeCycles >= 0) checkOutput("oe_cycles", oeInFrame, d.oeCycles);
          checkOutput("idle_after_complete", {cmd_oe, serial}, 2'b01);
        end
        bitsInFrame = 0;
        oeInFrame   = 0;
      end
      if (ack) begin
        ackSeen++;
        ackPending = 1'b1;
      end
      if (len_err) lenErrSeen++;
      lastSerial = serial;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at 500000 ns, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [PMAX-1:0] p;
    int              len, n;
    bit              ce, re;

    repeat (3) @(posedge sd_clock);
    #1;
    checkOutput("reset_serial", serial, 1);
    checkOutput("reset_cmd_oe", cmd_oe, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_complete", complete, 0);
    checkOutput("reset_len_err", len_err, 0);
    reset = 1'b1;
    @(posedge sd_clock); #1;

    $display("[TB] CMD0 / CMD17 / CMD8 known frames");
    pushLiteral(48'h40_0000_0000_95, 48);
    applyStimulus(CMD_PAYLOAD_LEN, 1'b1, {40'h40_0000_0000, 96'h0});
    waitIdle(1'b0);
    pushLiteral(48'h51_0000_0000_55, 48);
    applyStimulus(CMD_PAYLOAD_LEN, 1'b1, {40'h51_0000_0000, 96'h0});
    waitIdle(1'b0);
    pushLiteral(48'h48_0000_01AA_87, 48);
    applyStimulus(CMD_PAYLOAD_LEN, 1'b1, {40'h48_0000_01AA, 96'h0});
    waitIdle(1'b0);

    $display("[TB] R2 frame");
    p = randPayload();
    pushModel(R2_PAYLOAD_LEN, 1'b0, p, 136);
    applyStimulus(R2_PAYLOAD_LEN, 1'b0, p);
    waitIdle(1'b0);

    $display("[TB] CMD0 with enable stalls");
    pushLiteral(48'h40_0000_0000_95, -1);
    applyStimulus(CMD_PAYLOAD_LEN, 1'b1, {40'h40_0000_0000, 96'h0});
    waitIdle(1'b1);

    $display("[TB] random frames");
    for (int k = 0; k < 8; k++) begin
      len = (k == 0) ? PMAX : $urandom_range(1, PMAX);
      ce  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      p   = randPayload();
      pushModel(len, ce, p, re ? -1 : len + 7*int'(ce) + 1);
      applyStimulus(len, ce, p);
      waitIdle(re);
    end

    $display("[TB] length errors");
    applyBadLength(0);
    applyBadLength(PMAX + 1);

    $display("[TB] held load_send, back-to-back frames");
    pushLiteral(48'h51_0000_0000_55, 48);
    pushLiteral(48'h48_0000_01AA_87, 48);
    frame_len = LW'(CMD_PAYLOAD_LEN);
    crc_en    = 1'b1;
    parallel  = {40'h51_0000_0000, 96'h0};
    load_send = 1'b1;
    @(posedge sd_clock); #1;
    ackExp++;
    checkOutput("b2b_first_ack", ack, 1);
    parallel = {40'h48_0000_01AA, 96'h0};
    n = 0;
    while (!complete && n < 200) begin
      @(posedge sd_clock); #1;
      n++;
    end
    if (!complete) failNow("b2b_complete", "complete never rose within 200 cycles, expected 1");
    @(posedge sd_clock); #1;
    ackExp++;
    checkOutput("b2b_second_ack", ack, 1);
    load_send = 1'b0;
    waitIdle(1'b0);

    $display("[TB] reset in the middle of CMD8");
    pushLiteral(48'h48_0000_01AA_87, 48);
    applyStimulus(CMD_PAYLOAD_LEN, 1'b1, {40'h48_0000_01AA, 96'h0});
    n = 0;
    while (bitsInFrame < 20 && n < 200) begin
      @(posedge sd_clock); #1;
      n++;
    end
    if (bitsInFrame < 20) failNow("reset_wait", $sformatf("only %0d bits seen, expected 20", bitsInFrame));
    @(posedge sd_clock); #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_serial", serial, 1);
    checkOutput("abort_cmd_oe", cmd_oe, 0);
    checkOutput("abort_busy", busy, 0);
    bitQ.delete();
    doneQ.delete();
    repeat (2) @(posedge sd_clock);
    #1;
    reset = 1'b1;
    @(posedge sd_clock); #1;
    pushLiteral(48'h48_0000_01AA_87, 48);
    applyStimulus(CMD_PAYLOAD_LEN, 1'b1, {40'h48_0000_01AA, 96'h0});
    waitIdle(1'b0);

    repeat (4) @(posedge sd_clock);
    #1;
    checkOutput("queues_drained", bitQ.size() + doneQ.size(), 0);
    checkOutput("ack_count", ackSeen, ackExp);
    checkOutput("len_err_count", lenErrSeen, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_frame_serializer.md
# sd_cmd_frame_serializer

Parametrised CMD-line frame transmitter for the SD host/card command path. It generalises the fixed-size parallel-to-serial wrapper. The block takes a variable-length MSB-first payload of up to `PAYLOAD_MAX` bits and appends a serially computed CRC7 when enabled, followed by the end bit. It drives the CMD pin with output enable and reports `complete`. It sits between `cmd_phys` (or a card-side model) and `pad`, and serves both 48-bit command/R1-style frames and 136-bit R2 frames.

## Interface
- `PAYLOAD_MAX`, 136 — maximum payload bits held in the shift register.
- `LEN_W`, 8 — width of `frame_len`; must satisfy 2^`LEN_W` > `PAYLOAD_MAX`.
- `sd_clock`  in  1  — single clock; all state changes on its rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `enable`  in  1  — shift qualifier; 0 freezes the frame in place mid-transmission.
- `load_send`  in  1  — request; sampled only in IDLE.
- `frame_len`  in  `LEN_W`  — payload bit count, including start and transmission bits.
- `crc_en`  in  1  — 1 appends CRC7 over the payload; 0 appends nothing, which is R2 mode.
- `parallel`  in  `PAYLOAD_MAX`  — payload, left-justified; bit `PAYLOAD_MAX-1` is sent first.
- `serial`  out  1  — CMD line data; 1 when not transmitting.
- `cmd_oe`  out  1  — pad output enable; 1 from the first payload bit through the end bit.
- `busy`  out  1  — high in SHIFT, CRC and END.
- `ack`  out  1  — one-cycle pulse when a load is accepted.
- `complete`  out  1  — one-cycle pulse after the end bit has been driven.
- `len_err`  out  1  — one-cycle pulse when a load is rejected for a bad length.

## Operation
- States and transitions:
  - IDLE: `load_send` with a valid length goes to SHIFT.
  - SHIFT: goes to CRC if `crc_en` was latched, otherwise to END.
  - CRC → END → IDLE.
- IDLE with `load_send`=1:
  - If `frame_len` is 0 or greater than `PAYLOAD_MAX`, pulse `len_err`, stay in IDLE, leave `serial`/`cmd_oe` unchanged.
  - Otherwise latch `parallel`, `frame_len` and `crc_en`, clear CRC to 0, pulse `ack`, go to SHIFT.
- SHIFT: drive the shift-register MSB and shift left by one on each `enable` cycle. Feed each bit into CRC7 (x^7+x^3+1, serial LFSR). Leave after `frame_len` bits.
- CRC: shift out the 7 CRC bits MSB first. The CRC register does not update while being emitted.
- END: drive 1 for one enabled cycle. On leaving, pulse `complete` and drop `cmd_oe`.
- `load_send` while `busy` is ignored; there is no queueing.
- `parallel` is not re-sampled after acceptance, so the source may change it after `ack`.
- `bit_cnt` is `LEN_W` wide and counts down from `frame_len`-1. No wrap-around is permitted: transition to the next state when it reaches 0.

## Timing
- Reset values: `serial`=1, `cmd_oe`=0, `busy`=0, `ack`=0, `complete`=0, `len_err`=0, state IDLE, shift register 0, CRC 0.
- Latency:
  - Load accepted at edge n; the first payload bit appears on `serial` after edge n+1.
  - Frame length is `frame_len` + 7·`crc_en` + 1 enabled cycles.
- `complete` is high in the cycle the state returns to IDLE. A `load_send` in that same cycle is accepted, so frames can run back-to-back with no idle gap.
- `enable`=0 holds the state, counter, CRC and `serial` value. `busy`/`cmd_oe` stay asserted.
- `reset` asserted mid-frame aborts immediately and asynchronously to reset values. No `complete` pulse is issued.
- `ack`, `complete` and `len_err` are single-cycle regardless of `enable`.

## Structure
- Shared definitions package `sd_cmd_pkg`:
  - state encoding (IDLE/SHIFT/CRC/END)
  - CRC7 polynomial 7'h09
  - frame constants `CMD_PAYLOAD_LEN`=40 and `R2_PAYLOAD_LEN`=135
- One sub-module, `crc7_serial`, with ports `sd_clock`, `reset`, `clear`, `shift_en`, `din`, `crc[6:0]`. It is reused by the receive path for response checking.

## Test plan
- **CMD0:** `frame_len`=40, `crc_en`=1, payload 0x40_0000_0000. Required `serial` sequence: 0x40_0000_0000_95. `ack` at load; `complete` 48 cycles after the first bit.
- **CMD17:** payload 0x51_0000_0000 → serial 0x51_0000_0000_55. **CMD8:** payload 0x48_0000_01AA → serial 0x48_0000_01AA_87.
- **R2 mode:** `crc_en`=0, `frame_len`=135, arbitrary 135-bit payload. Required: payload verbatim, then 1; 136 bits total; `cmd_oe` high exactly 136 cycles.
- **Enable stalls:** toggle `enable` pseudo-randomly during a CMD0 frame. Required: identical bit sequence counted on enabled cycles; `serial` stable while `enable`=0.
- **Length errors and ignored requests:**
  - `frame_len`=0 → `len_err` pulse, line stays 1.
  - `frame_len`=137 → `len_err` pulse, line stays 1.
  - `load_send` held high during a frame → no second `ack` until the `complete` cycle, then a back-to-back frame starts with no idle bit.
- **Reset mid-frame:** assert `reset` low at bit 20 of CMD8. Required: `serial`=1 and `cmd_oe`=0 immediately, no `complete`; the next load transmits CMD8 correctly.
